ex_div_sched: RTL and testbench

Shared iterative-divider scheduler for the dual-issue EX1 stage. It accepts integer divide/modulo requests from both issue lanes and runs them one after another, lane 0 first, on a single radix-2 restoring divider. It holds the pipeline with `stall` until both results are ready. The results are registered so the EX1→EX2 pipeline register captures them on the cycle `done` is high.

---
 rtl/ex_div_sched_if.sv | 31 +++
 rtl/ex_div_sched.sv | 185 ++++++++++++++++++
 tb/tb_ex_div_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ex_div_sched_if.sv
// EX1 <-> shared divider scheduler bundle.
// Master is the EX1 issue side, slave is the scheduler.
interface ex_div_sched_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            req0;
    logic            req1;
    logic [1:0]      op0;
    logic [1:0]      op1;
    logic [XLEN-1:0] src_a0;
    logic [XLEN-1:0] src_b0;
    logic [XLEN-1:0] src_a1;
    logic [XLEN-1:0] src_b1;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] res0;
    logic [XLEN-1:0] res1;

    modport master (
        output flush, req0, req1, op0, op1,
        output src_a0, src_b0, src_a1, src_b1,
        input  stall, done, res0, res1
    );

    modport slave (
        input  flush, req0, req1, op0, op1,
        input  src_a0, src_b0, src_a1, src_b1,
        output stall, done, res0, res1
    );
endinterface

// File: rtl/ex_div_sched.sv
// Dual-lane divide scheduler: lane 0 then lane 1 on one
// radix-2 restoring divider, stalling EX1 until both finish.
module ex_div_sched #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          aresetn,
    ex_div_sched_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        RUN0,
        RUN1,
        DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            mod0_q;
    logic [XLEN-1:0] a0_q;
    logic            req1_q;
    logic [1:0]      op1_q;
    logic [XLEN-1:0] a1_q;
    logic [XLEN-1:0] b1_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic            qneg_q;
    logic            rneg_q;
    logic            done_q;
    logic [XLEN-1:0] res0_q;
    logic [XLEN-1:0] res1_q;

    logic [1:0]      s_op;
    logic [XLEN-1:0] s_a;
    logic [XLEN-1:0] s_b;
    logic            s_sa;
    logic            s_sb;
    logic [XLEN-1:0] s_abs_a;
    logic [XLEN-1:0] s_abs_b;

    // Operand setup: fresh inputs when leaving IDLE,
    // the latched lane 1 when moving RUN0 -> RUN1.
    always_comb begin
        s_op = bus.op1;
        s_a  = bus.src_a1;
        s_b  = bus.src_b1;
        if (state_q == IDLE) begin
            if (bus.req0) begin
                s_op = bus.op0;
                s_a  = bus.src_a0;
                s_b  = bus.src_b0;
            end
        end else begin
            s_op = op1_q;
            s_a  = a1_q;
            s_b  = b1_q;
        end
        s_sa    = ~s_op[1] & s_a[XLEN-1];
        s_sb    = ~s_op[1] & s_b[XLEN-1];
        s_abs_a = s_sa ? -s_a : s_a;
        s_abs_b = s_sb ? -s_b : s_b;
    end

    logic [XLEN:0]   it_t;
    logic [XLEN:0]   it_diff;
    logic            it_ge;
    logic [XLEN-1:0] quo_n;
    logic [XLEN-1:0] rem_n;
    logic            cur_mod;
    logic [XLEN-1:0] cur_raw;
    logic            dz;
    logic            last;
    logic [XLEN-1:0] result;

    always_comb begin
        it_t    = {rem_q, quo_q[XLEN-1]};
        it_diff = it_t - {1'b0, dvs_q};
        it_ge   = ~it_diff[XLEN];
        rem_n   = it_ge ? it_diff[XLEN-1:0] : it_t[XLEN-1:0];
        quo_n   = {quo_q[XLEN-2:0], it_ge};
        cur_mod = (state_q == RUN0) ? mod0_q : op1_q[0];
        cur_raw = (state_q == RUN0) ? a0_q : a1_q;
        dz      = (dvs_q == '0);
        last    = dz | (cnt_q == '0);
        result  = '1;
        if (dz) begin
            result = cur_mod ? cur_raw : '1;
        end else if (cur_mod) begin
            result = rneg_q ? -rem_n : rem_n;
        end else begin
            result = qneg_q ? -quo_n : quo_n;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mod0_q  <= 1'b0;
            a0_q    <= '0;
            req1_q  <= 1'b0;
            op1_q   <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.req0 | bus.req1) begin
                            mod0_q  <= bus.op0[0];
                            a0_q    <= bus.src_a0;
                            req1_q  <= bus.req1;
                            op1_q   <= bus.op1;
                            a1_q    <= bus.src_a1;
                            b1_q    <= bus.src_b1;
                            quo_q   <= s_abs_a;
                            rem_q   <= '0;
                            dvs_q   <= s_abs_b;
                            qneg_q  <= s_sa ^ s_sb;
                            rneg_q  <= s_sa;
                            cnt_q   <= CW'(XLEN - 1);
                            state_q <= bus.req0 ? RUN0 : RUN1;
                        end
                    end
                    RUN0: begin
                        if (last) begin
                            res0_q <= result;
                            if (req1_q) begin
                                quo_q   <= s_abs_a;
                                rem_q   <= '0;
                                dvs_q   <= s_abs_b;
                                qneg_q  <= s_sa ^ s_sb;
                                rneg_q  <= s_sa;
                                cnt_q   <= CW'(XLEN - 1);
                                state_q <= RUN1;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end else begin
                            quo_q <= quo_n;
                            rem_q <= rem_n;
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    RUN1: begin
                        if (last) begin
                            res1_q  <= result;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            quo_q <= quo_n;
                            rem_q <= rem_n;
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.stall = (state_q == RUN0) | (state_q == RUN1)
                     | ((state_q == IDLE) & (bus.req0 | bus.req1)
                        & ~bus.flush);
    assign bus.done  = done_q;
    assign bus.res0  = res0_q;
    assign bus.res1  = res1_q;
endmodule

// File: tb/tb_ex_div_sched.sv
// Directed bench for ex_div_sched: latency, stall shape,
// signed/unsigned results, div-by-zero, flush and async reset.
module tb_ex_div_sched;
    logic clk;
    logic aresetn;
    int   ntests;
    int   nfail;

    ex_div_sched_if #(.XLEN(32)) bus ();

    ex_div_sched #(.XLEN(32)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        bus.flush  = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.op0    = 2'b00;
        bus.op1    = 2'b00;
        bus.src_a0 = '0;
        bus.src_b0 = '0;
        bus.src_a1 = '0;
        bus.src_b1 = '0;
    endtask

    // Issue at cycle T, hold until done, check latency and stall.
    task automatic do_req(input string tag,
                          input logic r0, input logic r1,
                          input logic [1:0] o0,
                          input logic [31:0] a0,
                          input logic [31:0] b0,
                          input logic [1:0] o1,
                          input logic [31:0] a1,
                          input logic [31:0] b1,
                          input int lat);
        int n;
        int bad;
        bus.req0   = r0;
        bus.req1   = r1;
        bus.op0    = o0;
        bus.op1    = o1;
        bus.src_a0 = a0;
        bus.src_b0 = b0;
        bus.src_a1 = a1;
        bus.src_b1 = b1;
        #1;
        chk({tag, " stall@T"}, 32'(bus.stall), 32'd1);
        n   = 0;
        bad = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done === 1'b1) break;
            if (bus.stall !== 1'b1) bad++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " stall gaps"}, 32'(bad), 32'd0);
        chk({tag, " stall@done"}, 32'(bus.stall), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        ntests  = 0;
        nfail   = 0;
        aresetn = 1'b0;
        idle_in();
        #12;
        chk("rst stall", 32'(bus.stall), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst res0", bus.res0, 32'h0);
        chk("rst res1", bus.res1, 32'h0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        do_req("div100/7", 1, 0, 2'b00, 100, 7,
               2'b00, 0, 0, 33);
        chk("div100/7 res0", bus.res0, 32'd14);
        do_req("mod100/7", 1, 0, 2'b01, 100, 7,
               2'b00, 0, 0, 33);
        chk("mod100/7 res0", bus.res0, 32'd2);

        do_req("dual", 1, 1, 2'b00, -32'sd100, 7,
               2'b11, 32'hFFFF_FFFF, 10, 65);
        chk("dual res0", bus.res0, 32'hFFFF_FFF2);
        chk("dual res1", bus.res1, 32'd5);

        do_req("ovf div", 1, 0, 2'b00, 32'h8000_0000,
               32'hFFFF_FFFF, 2'b00, 0, 0, 33);
        chk("ovf div res0", bus.res0, 32'h8000_0000);
        do_req("ovf mod", 1, 0, 2'b01, 32'h8000_0000,
               32'hFFFF_FFFF, 2'b00, 0, 0, 33);
        chk("ovf mod res0", bus.res0, 32'h0);

        do_req("divu5/0", 1, 0, 2'b10, 5, 0,
               2'b00, 0, 0, 2);
        chk("divu5/0 res0", bus.res0, 32'hFFFF_FFFF);
        do_req("mod-5/0", 1, 0, 2'b01, -32'sd5, 0,
               2'b00, 0, 0, 2);
        chk("mod-5/0 res0", bus.res0, 32'hFFFF_FFFB);

        do_req("dual dz", 1, 1, 2'b10, 9, 0,
               2'b11, 9, 0, 3);
        chk("dual dz res0", bus.res0, 32'hFFFF_FFFF);
        chk("dual dz res1", bus.res1, 32'd9);

        do_req("lane1 7/-2", 0, 1, 2'b00, 0, 0,
               2'b00, 7, -32'sd2, 33);
        chk("lane1 res1", bus.res1, 32'hFFFF_FFFD);
        chk("lane1 res0 kept", bus.res0, 32'hFFFF_FFFF);

        // Flush a lane-0 run at T+10.
        bus.req0   = 1'b1;
        bus.op0    = 2'b00;
        bus.src_a0 = 32'd1000;
        bus.src_b0 = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("flush no early done", 32'(bus.done), 32'd0);
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.req0  = 1'b0;
        #1;
        chk("flush stall idle", 32'(bus.stall), 32'd0);
        chk("flush done", 32'(bus.done), 32'd0);
        chk("flush res0 kept", bus.res0, 32'hFFFF_FFFF);
        bus.req0 = 1'b1;
        #1;
        chk("flush stall req", 32'(bus.stall), 32'd1);
        do_req("post flush", 1, 0, 2'b00, 1000, 3,
               2'b00, 0, 0, 33);
        chk("post flush res0", bus.res0, 32'd333);

        // Async reset while lane 1 is iterating.
        bus.req0   = 1'b1;
        bus.req1   = 1'b1;
        bus.op0    = 2'b00;
        bus.op1    = 2'b10;
        bus.src_a0 = 32'd50;
        bus.src_b0 = 32'd5;
        bus.src_a1 = 32'd40;
        bus.src_b1 = 32'd3;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre-rst res0", bus.res0, 32'd10);
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst res0", bus.res0, 32'h0);
        chk("arst res1", bus.res1, 32'h0);
        chk("arst done", 32'(bus.done), 32'd0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        #1;
        chk("arst stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1;
        chk("arst stall idle", 32'(bus.stall), 32'd0);
        chk("arst idle done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
